bch_stream_encoder: RTL
=======================

// Module: bch_stream_encoder
// PURPOSE
//  Parametrised systematic binary BCH/cyclic encoder, bit-serial, valid/ready on both sides.
//  Passes K info bits through, then appends N-K parity bits; frames are delimited by m_sof/m_last.
//  Sits between the framer/scrambler and the modulator mapper in the TX chain.
//  Default parameters give BCH(63,51).
// PARAMETERS
//  N         63             codeword length in bits; N > K, N <= 1023
//  K         51             info bits per frame; K >= 1
//  GEN_POLY  13'h1539       generator g(x), width N-K+1, bit i = coeff x^i; MSB and LSB must be 1
//                           (default: x^12+x^10+x^8+x^5+x^4+x^3+1)
//  localparam P = N-K       parity length and LFSR width
//  localparam CW = $clog2(N+1)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  s_valid     in   1   input info bit valid
//  s_ready     out  1   encoder accepts s_data this cycle
//  s_data      in   1   info bit; first bit = highest-degree message coefficient
//  m_valid     out  1   output bit valid
//  m_ready     in   1   downstream accepts m_data
//  m_data      out  1   codeword bit, registered
//  m_sof       out  1   qualifies the first bit of a codeword
//  m_last      out  1   qualifies the last parity bit of a codeword
//  m_parity    out  1   current m_data is a parity bit
//  k_len       in   CW  shortened info length; present only with BCH_ENC_SHORTEN_EN
// BEHAVIOUR
//  Reset: m_valid, m_data, m_sof, m_last, m_parity = 0; LFSR r[P-1:0] = 0; cnt = 0; state = DATA.
//   Reset mid-frame discards the partial frame, and no m_last is produced for it.
//  Output register: slot_free = !m_valid | m_ready.
//   Loads on slot_free; clears m_valid on m_ready when nothing new is loaded.
//   Latency is 1 cycle from input acceptance to m_valid.
//   Outputs hold stable while m_valid & !m_ready.
//  FSM DATA:
//   s_ready = slot_free.
//   On s_valid & s_ready:
//    - m_data <= s_data; m_valid <= 1; m_sof <= (cnt==0); m_parity <= 0.
//    - fb = s_data ^ r[P-1]; r <= {r[P-2:0],1'b0} ^ ({P{fb}} & GEN_POLY[P-1:0]).
//    - cnt++.
//   When the bit loaded is info index KL-1, go to PARITY.
//  FSM PARITY:
//   s_ready = 0.
//   On slot_free:
//    - m_data <= r[P-1]; m_valid <= 1; m_parity <= 1; r <= {r[P-2:0],1'b0}; cnt++.
//    - m_last <= 1 on parity bit P-1; then r <= 0, cnt <= 0, state <= DATA.
//  Back-to-back frames: s_ready may assert the cycle after the last parity bit loads; no extra bubble.
//  Parity leaves MSB first: r[P-1] first, r[0] last.
//  Throughput is 1 bit/clk when s_valid and m_ready are held high.
//  Each frame emits exactly KL+P bits.
//  s_valid ignored in PARITY; s_data is not sampled unless s_valid & s_ready.
// CONFIGURATION
//  BCH_ENC_SHORTEN_EN defined:
//   - k_len port exists; sampled as KL when cnt==0 and the first info bit is accepted.
//   - KL held constant for the rest of the frame.
//   - k_len==0 or k_len>K is treated as KL=K.
//   - Shortened code: leading zeros implied, not transmitted.
//  BCH_ENC_SHORTEN_EN undefined:
//   - No k_len port; KL=K constant.
// TESTING
//  1 All-zero frame: 51 zeros in -> 63 zeros out; m_sof on bit 0, m_last on bit 62, m_parity on bits 51..62.
//  2 50 zeros then a 1 -> info echoed; parity = 12'h539, serially 0,1,0,1,0,0,1,1,1,0,0,1.
//  3 Random frames with m_ready 50% random stalls -> bit stream identical to golden model (poly division);
//    s_ready=0 during all 12 parity cycles.
//  4 Three frames back-to-back, s_valid and m_ready held high -> 189 consecutive m_valid cycles, no gaps.
//  5 rst asserted after 20 info bits -> next cycle m_valid=0, r=0; the following frame encodes correctly from m_sof.
//  6 (BCH_ENC_SHORTEN_EN) k_len=1, data 1 -> 13-bit frame: 1, then 0x539 parity; k_len=0 -> full 63-bit frame.

Source files
------------

// File: rtl/bch_stream_encoder_if.sv
// Bit-serial stream bundle around the BCH encoder: info bits in (s_*), codeword bits out (m_*).
// slave = encoder view, master = upstream/downstream (bench) view.
interface bch_stream_encoder_if;
    logic s_valid;
    logic s_ready;
    logic s_data;
    logic m_valid;
    logic m_ready;
    logic m_data;
    logic m_sof;
    logic m_last;
    logic m_parity;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_last, m_parity
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_last, m_parity
    );
endinterface

// File: rtl/bch_stream_encoder.sv
// Bit-serial systematic BCH encoder: KL info bits pass through, then N-K parity bits MSB first; 1-cycle latency,
// stalls on m_ready with outputs held; BCH_ENC_SHORTEN_EN adds k_len_i for per-frame shortened codes.
module bch_stream_encoder #(
    parameter int             N        = 63,
    parameter int             K        = 51,
    parameter logic [N-K:0]   GEN_POLY = 13'h1539
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef BCH_ENC_SHORTEN_EN
    input  logic [$clog2(N+1)-1:0] k_len_i,
`endif
    bch_stream_encoder_if.slave    bus
);
    localparam int              P      = N - K;
    localparam int              CW     = $clog2(N + 1);
    localparam logic [CW-1:0]   K_CW   = CW'(K);
    localparam logic [CW-1:0]   ONE_CW = CW'(1);
    localparam logic [CW-1:0]   PM1_CW = CW'(P - 1);

    typedef enum logic {ST_DATA, ST_PARITY} state_e;

    state_e         state_q, state_d;
    logic [P-1:0]   r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  kl_cur;
    logic           m_valid_q, m_valid_d;
    logic           m_data_q, m_data_d;
    logic           m_sof_q, m_sof_d;
    logic           m_last_q, m_last_d;
    logic           m_parity_q, m_parity_d;
    logic           slot_free, accept, s_ready, fb;

    assign slot_free = ~m_valid_q | bus.m_ready;
    assign accept    = (state_q == ST_DATA) & bus.s_valid & slot_free;

`ifdef BCH_ENC_SHORTEN_EN
    logic [CW-1:0] kl_q, kl_req;

    // Out-of-range request falls back to the full code.
    assign kl_req = ((k_len_i == '0) || (k_len_i > K_CW)) ? K_CW : k_len_i;
    assign kl_cur = (cnt_q == '0) ? kl_req : kl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            kl_q <= K_CW;
        end else if (accept && (cnt_q == '0)) begin
            kl_q <= kl_req;
        end
    end
`else
    assign kl_cur = K_CW;
`endif

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        m_valid_d  = m_valid_q & ~bus.m_ready;
        m_data_d   = m_data_q;
        m_sof_d    = m_sof_q;
        m_last_d   = m_last_q;
        m_parity_d = m_parity_q;
        s_ready    = 1'b0;
        fb         = 1'b0;
        case (state_q)
            ST_DATA: begin
                s_ready = slot_free;
                if (accept) begin
                    m_data_d   = bus.s_data;
                    m_valid_d  = 1'b1;
                    m_sof_d    = (cnt_q == '0);
                    m_last_d   = 1'b0;
                    m_parity_d = 1'b0;
                    fb         = bus.s_data ^ r_q[P-1];
                    r_d        = {r_q[P-2:0], 1'b0} ^ ({P{fb}} & GEN_POLY[P-1:0]);
                    cnt_d      = cnt_q + ONE_CW;
                    if (cnt_q == kl_cur - ONE_CW) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (slot_free) begin
                    m_data_d   = r_q[P-1];
                    m_valid_d  = 1'b1;
                    m_sof_d    = 1'b0;
                    m_parity_d = 1'b1;
                    r_d        = {r_q[P-2:0], 1'b0};
                    cnt_d      = cnt_q + ONE_CW;
                    m_last_d   = (cnt_q == kl_cur + PM1_CW);
                    // Last parity bit frees the LFSR so the next frame can start on the following cycle.
                    if (cnt_q == kl_cur + PM1_CW) begin
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DATA;
            r_q        <= '0;
            cnt_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 1'b0;
            m_sof_q    <= 1'b0;
            m_last_q   <= 1'b0;
            m_parity_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_last_q   <= m_last_d;
            m_parity_q <= m_parity_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_sof    = m_sof_q;
    assign bus.m_last   = m_last_q;
    assign bus.m_parity = m_parity_q;
endmodule
